// File: rtl/aux_prog_divider.sv
// rtl/aux_prog_divider.sv - multi-channel run-time programmable clock divider
// Each channel toggles clk_out every `act` enabled cycles; reloads from a shadow only at phase boundaries.
module aux_prog_divider #(
    parameter int Channels    = 4,
    parameter int CntBit      = 32,
    parameter int DefaultHalf = 50_000_000,
    localparam int ChBit      = (Channels > 1) ? $clog2(Channels) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [Channels-1:0] en,
    input  logic                sync,
    input  logic                cfg_we,
    input  logic [ChBit-1:0]    cfg_ch,
    input  logic [CntBit-1:0]   cfg_half,
    output logic [Channels-1:0] clk_out,
    output logic [Channels-1:0] tick,
    output logic [Channels-1:0] pending
);

    localparam logic [CntBit-1:0] ResetHalf = CntBit'(DefaultHalf);

    logic [CntBit-1:0]   cnt_q [Channels];
    logic [CntBit-1:0]   cnt_d [Channels];
    logic [CntBit-1:0]   act_q [Channels];
    logic [CntBit-1:0]   act_d [Channels];
    logic [CntBit-1:0]   shd_q [Channels];
    logic [CntBit-1:0]   shd_d [Channels];
    logic [Channels-1:0] clk_out_q, clk_out_d;
    logic [Channels-1:0] tick_q, tick_d;
    logic [Channels-1:0] pending_q, pending_d;
    logic [Channels-1:0] wr_hit;
    logic [Channels-1:0] terminal;
    logic [CntBit-1:0]   next_half [Channels];

    always_comb begin
        for (int i = 0; i < Channels; i++) begin
            wr_hit[i]    = cfg_we && (int'(cfg_ch) == i);
            // A write landing on a reload point beats the stale shadow.
            next_half[i] = wr_hit[i] ? cfg_half : shd_q[i];
            terminal[i]  = en[i] && (act_q[i] != '0)
                           && (cnt_q[i] == act_q[i] - CntBit'(1));

            cnt_d[i]     = cnt_q[i];
            act_d[i]     = act_q[i];
            shd_d[i]     = next_half[i];
            clk_out_d[i] = clk_out_q[i];
            tick_d[i]    = 1'b0;
            pending_d[i] = pending_q[i] | wr_hit[i];

            if (sync || (act_q[i] == '0)) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                act_d[i]     = next_half[i];
                pending_d[i] = 1'b0;
            end else if (terminal[i]) begin
                cnt_d[i]     = '0;
                act_d[i]     = next_half[i];
                pending_d[i] = 1'b0;
                // Reloading to zero parks the output low instead of emitting a runt high.
                clk_out_d[i] = ~clk_out_q[i] && (next_half[i] != '0);
                tick_d[i]    = clk_out_d[i];
            end else if (en[i]) begin
                cnt_d[i] = cnt_q[i] + CntBit'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Channels; i++) begin
                cnt_q[i] <= '0;
                act_q[i] <= ResetHalf;
                shd_q[i] <= ResetHalf;
            end
            clk_out_q <= '0;
            tick_q    <= '0;
            pending_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            shd_q     <= shd_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_aux_prog_divider.sv
// tb/tb_aux_prog_divider.sv - self-checking bench for aux_prog_divider
// Two instances: A (2 channels, half 3) and B (3 channels, half 2) for out-of-range channel writes.
module tb_aux_prog_divider;

    logic       clk;
    logic       rst_n;
    logic       sync;
    logic [1:0] en_a, clk_out_a, tick_a, pending_a;
    logic       cfg_we_a;
    logic       cfg_ch_a;
    logic [7:0] cfg_half_a;
    logic [2:0] en_b, clk_out_b, tick_b, pending_b;
    logic       cfg_we_b;
    logic [1:0] cfg_ch_b;
    logic [7:0] cfg_half_b;

    int n_chk  = 0;
    int n_fail = 0;
    int edge_no = 0;
    int tq[$];

    aux_prog_divider #(.Channels(2), .CntBit(8), .DefaultHalf(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .sync(sync), .cfg_we(cfg_we_a),
        .cfg_ch(cfg_ch_a), .cfg_half(cfg_half_a), .clk_out(clk_out_a),
        .tick(tick_a), .pending(pending_a)
    );

    aux_prog_divider #(.Channels(3), .CntBit(8), .DefaultHalf(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .sync(sync), .cfg_we(cfg_we_b),
        .cfg_ch(cfg_ch_b), .cfg_half(cfg_half_b), .clk_out(clk_out_b),
        .tick(tick_b), .pending(pending_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: level, cycles left in the current phase, current and next half, pending flag.
    typedef struct {
        int lvl;
        int tk;
        int left;
        int cur;
        int nxt;
        int pend;
    } mch_t;

    mch_t m [5];

    function automatic mch_t mreset(int half);
        mch_t s;
        s.lvl = 0; s.tk = 0; s.pend = 0;
        s.left = half; s.cur = half; s.nxt = half;
        return s;
    endfunction

    function automatic mch_t mstep(mch_t s, bit sy, bit e, bit wr, int half);
        mch_t n = s;
        n.tk = 0;
        if (wr) n.nxt = half;
        if (sy || s.cur == 0) begin
            n.cur = n.nxt; n.left = n.cur; n.lvl = 0; n.pend = 0;
        end else if (e && s.left == 1) begin
            n.cur  = n.nxt;
            n.left = n.cur;
            n.pend = 0;
            n.lvl  = (n.cur == 0) ? 0 : 1 - s.lvl;
            n.tk   = (n.lvl == 1) ? 1 : 0;
        end else begin
            if (e) n.left = s.left - 1;
            if (wr) n.pend = 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) m[k] = mreset(3);
            for (int k = 2; k < 5; k++) m[k] = mreset(2);
            edge_no = 0;
        end else begin
            for (int k = 0; k < 2; k++)
                m[k] = mstep(m[k], sync, en_a[k], cfg_we_a && (int'(cfg_ch_a) == k), int'(cfg_half_a));
            for (int k = 0; k < 3; k++)
                m[2+k] = mstep(m[2+k], sync, en_b[k], cfg_we_b && (int'(cfg_ch_b) == k), int'(cfg_half_b));
            edge_no = edge_no + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_no, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [1:0] ca, ta, pa;
        logic [2:0] cb, tb, pb;
        for (int k = 0; k < 2; k++) begin
            ca[k] = m[k].lvl[0]; ta[k] = m[k].tk[0]; pa[k] = m[k].pend[0];
        end
        for (int k = 0; k < 3; k++) begin
            cb[k] = m[2+k].lvl[0]; tb[k] = m[2+k].tk[0]; pb[k] = m[2+k].pend[0];
        end
        chk("model_a_clk_out", 32'(clk_out_a), 32'(ca));
        chk("model_a_tick",    32'(tick_a),    32'(ta));
        chk("model_a_pending", 32'(pending_a), 32'(pa));
        chk("model_b_clk_out", 32'(clk_out_b), 32'(cb));
        chk("model_b_tick",    32'(tick_b),    32'(tb));
        chk("model_b_pending", 32'(pending_b), 32'(pb));
        if (tick_a[0]) tq.push_back(edge_no);
    end

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_ticks(input string name);
        if (tq.size() < 3) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got %0d ticks expected at least 3", name, tq.size());
        end else begin
            chk({name, "_1"}, tq[0], 3);
            chk({name, "_2"}, tq[1], 9);
            chk({name, "_3"}, tq[2], 15);
        end
    endtask

    initial begin
        rst_n = 1'b0; sync = 1'b0;
        en_a = 2'b00; cfg_we_a = 1'b0; cfg_ch_a = 1'b0; cfg_half_a = 8'd0;
        en_b = 3'b000; cfg_we_b = 1'b0; cfg_ch_b = 2'd0; cfg_half_b = 8'd0;
        go(2);
        chk("reset_clk_out", 32'(clk_out_a), 0);
        chk("reset_pending", 32'(pending_a), 0);
        rst_n = 1'b1; en_a = 2'b11; en_b = 3'b111;
        tq.delete();

        // Default rate, then reprogram ch1 to half 5 at cycle 4.
        go(3);
        chk("first_rise", 32'(clk_out_a), 32'h3);
        chk("first_tick", 32'(tick_a), 32'h3);
        cfg_we_a = 1'b1; cfg_ch_a = 1'b1; cfg_half_a = 8'd5;
        go(1);
        cfg_we_a = 1'b0;
        chk("pend_set", 32'(pending_a), 32'h2);
        go(2);
        chk("pend_clr", 32'(pending_a), 0);
        chk("e6_clk", 32'(clk_out_a), 0);
        go(5);
        chk("e11_clk", 32'(clk_out_a), 32'h3);
        chk("e11_tick", 32'(tick_a), 32'h2);
        go(5);
        chk("e16_clk", 32'(clk_out_a), 32'h1);
        chk_ticks("tick_edges");

        // Stop ch0 with half 0, restart with half 1.
        cfg_we_a = 1'b1; cfg_ch_a = 1'b0; cfg_half_a = 8'd0;
        go(1);
        cfg_we_a = 1'b0;
        chk("stop_pend", 32'(pending_a[0]), 1);
        go(1);
        chk("stop_low", 32'(clk_out_a[0]), 0);
        go(4);
        cfg_we_a = 1'b1; cfg_half_a = 8'd1;
        go(1);
        cfg_we_a = 1'b0;
        chk("restart_low", 32'(clk_out_a[0]), 0);
        go(1);
        chk("restart_rise", 32'(clk_out_a[0]), 1);
        chk("restart_tick", 32'(tick_a[0]), 1);
        go(1);
        chk("fast_low", 32'(clk_out_a[0]), 0);
        go(1);
        chk("fast_high", 32'(clk_out_a[0]), 1);

        // Write on a terminal-count cycle goes straight to the active half.
        cfg_we_a = 1'b1; cfg_half_a = 8'd3;
        go(1);
        cfg_we_a = 1'b0;
        chk("wr_term_pend", 32'(pending_a[0]), 0);
        chk("wr_term_clk", 32'(clk_out_a[0]), 0);

        // Freeze ch0 for 4 cycles; write to a nonexistent channel of B.
        go(4);
        en_a[0] = 1'b0;
        cfg_we_b = 1'b1; cfg_ch_b = 2'd3; cfg_half_b = 8'd7;
        go(1);
        cfg_we_b = 1'b0;
        chk("bad_ch_pend", 32'(pending_b), 0);
        chk("bad_ch_clk", 32'(clk_out_b), 0);
        go(2);
        chk("bad_ch_rise", 32'(clk_out_b), 32'h7);
        go(1);
        en_a[0] = 1'b1;
        go(1);
        chk("freeze_hold", 32'(clk_out_a), 32'h1);
        go(1);
        chk("freeze_fall", 32'(clk_out_a), 0);

        // Sync with a same-cycle write to B ch0.
        go(3);
        sync = 1'b1;
        cfg_we_b = 1'b1; cfg_ch_b = 2'd0; cfg_half_b = 8'd4;
        go(1);
        sync = 1'b0; cfg_we_b = 1'b0;
        chk("sync_clk_a", 32'(clk_out_a), 0);
        chk("sync_tick_a", 32'(tick_a), 0);
        chk("sync_clk_b", 32'(clk_out_b), 0);
        chk("sync_pend_b", 32'(pending_b), 0);
        go(2);
        chk("sync_b_e2", 32'(clk_out_b), 32'h6);
        go(1);
        chk("sync_a_e3", 32'(clk_out_a), 32'h1);
        chk("sync_tick_e3", 32'(tick_a), 32'h1);
        go(1);
        chk("sync_b_e4", 32'(clk_out_b), 32'h1);
        go(1);
        chk("sync_a_e5", 32'(clk_out_a), 32'h3);
        chk("sync_tick_e5", 32'(tick_a), 32'h2);

        // Asynchronous reset with a write still pending.
        cfg_we_a = 1'b1; cfg_ch_a = 1'b1; cfg_half_a = 8'd7;
        go(1);
        cfg_we_a = 1'b0;
        chk("pre_rst_pend", 32'(pending_a), 32'h2);
        rst_n = 1'b0;
        #2;
        chk("async_clk_a", 32'(clk_out_a), 0);
        chk("async_pend_a", 32'(pending_a), 0);
        chk("async_clk_b", 32'(clk_out_b), 0);
        go(2);
        rst_n = 1'b1;
        tq.delete();
        go(2);
        chk("rerun_e2", 32'(clk_out_a), 0);
        go(1);
        chk("rerun_e3", 32'(clk_out_a), 32'h3);
        go(3);
        chk("rerun_e6", 32'(clk_out_a), 0);
        go(10);
        chk_ticks("rerun_ticks");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aux_prog_divider.md
# aux_prog_divider

Multi-channel, run-time programmable clock-enable/divider generator, the parametrised successor to the team's fixed single-output divider. Each channel produces a square wave `clk_out[i]` and a one-cycle `tick[i]` strobe at a per-channel half-period loaded through a simple write port. Reloads are glitch-free, and all channels can be phase-aligned by a common sync pulse. It sits beside the display/scan and debounce logic that need several slow rates from the single board clock.

## Interface
- `Channels`, 4, number of independent divider channels (1..16).
- `CntBit`, 32, width of the half-period value and of each channel counter.
- `DefaultHalf`, 50_000_000, half-period in clk cycles loaded into every channel at reset (must be < 2^CntBit).
- `ChBit`, derived: max(1, ceil(log2(Channels))); not overridable.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  Channels  per-channel count enable.
- `sync`  in  1  synchronous phase-align pulse, all channels.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_ch`  in  ChBit  target channel of write.
- `cfg_half`  in  CntBit  new half-period for target channel.
- `clk_out`  out  Channels  divided square waves.
- `tick`  out  Channels  one-cycle strobe on each 0->1 of `clk_out[i]`.
- `pending`  out  Channels  shadow half-period written but not yet active.

## Operation
- Per channel: counter `cnt`, active half-period `act`, shadow `shd`, output `clk_out`, `pending`.
- Reset: `cnt`=0, `act`=`shd`=DefaultHalf, `clk_out`=0, `tick`=0, `pending`=0.
- Write: `cfg_we` with `cfg_ch` < Channels stores `cfg_half` in `shd[cfg_ch]` and sets `pending`. `cfg_ch` >= Channels is ignored, with no state change.
- Count: when `en[i]`=1 and `act`≠0, `cnt` increments each cycle.
- Terminal (`cnt`==`act`-1 with `en[i]`): `clk_out` toggles, `cnt`<=0, `act`<=`shd`, `pending`<=0. A new rate therefore takes effect only at a half-period boundary, with no runt pulses.
- `en[i]`=0: `cnt`, `clk_out` and `act` freeze. A write still updates `shd` and stays pending until the next terminal count.
- `act`==0 (stopped): `cnt` held 0 and `clk_out` forced 0. `shd` is copied to `act` every cycle, so a nonzero write restarts the channel immediately from `cnt`=0 and `clk_out`=0.
- `sync`: every channel sets `cnt`<=0, `clk_out`<=0, `act`<=`shd`, `pending`<=0, regardless of `en`. `sync` has priority over terminal count.
- Write and `sync` in the same cycle: the written value goes straight to `act` and `pending` stays 0.
- Write and terminal count on the same channel in the same cycle: the written value goes to `act` and `pending` stays 0. The write wins over the stale shadow.
- `tick[i]` is registered and high for exactly the cycle in which `clk_out[i]` is first 1 after a 0->1 toggle. It is never asserted on a `sync` or stop.
- Arithmetic: `cnt` is CntBit wide and compared against `act`-1, which is never evaluated when `act`==0. There is no wrap-around because `cnt` < `act` is an invariant.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- After `rst_n` release with `en`=1: `clk_out` rises after DefaultHalf edges and has a period of 2·DefaultHalf, 50% duty.
- `act`=1 gives `clk_out` toggling every cycle (clk/2), with `tick` high every other cycle.
- Write-to-effect latency: up to `act` cycles for a running channel; 1 cycle for a stopped channel or with `sync`.
- `pending` rises the cycle after `cfg_we` and falls the cycle after the terminal count that consumed it.
- Reset mid-operation: all state returns to its reset value asynchronously, and pending writes are lost.

## Test plan
- Use overrides Channels=2, CntBit=8, DefaultHalf=3. Release reset with `en`=2'b11 -> `clk_out` rises on edge 3, period 6, and `tick` pulses on edges 3, 9, 15.
- Write ch1 half=5 at cycle 4 -> `pending[1]`=1 until the next ch1 toggle, then half-periods of exactly 5. No high or low phase is shorter than 3 during the switch.
- Write ch0 half=0, then half=1 six cycles later -> `clk_out[0]` goes low and stays low, then toggles every cycle starting one cycle after the second write.
- Drop `en[0]` for 4 cycles mid-phase -> `clk_out[0]` and the phase freeze, then resume with the phase stretched by exactly 4 cycles while ch1 is unaffected. Also check that a write with `cfg_ch`=3 is ignored.
- Run channels at halves 3 and 5, then pulse `sync` -> both outputs go to 0 on the next edge with no tick, then rise together 3 and 5 cycles later. Also check that a write issued in the `sync` cycle is applied immediately.
- Assert `rst_n`=0 mid-phase with a pending write -> all outputs are 0 immediately; after release, the timing matches the default-rate scenario.
